// File: rtl/regfile_dump_ctrl_if.sv
// regfile_dump_ctrl_if: start/register-read/UART-TX bundle for the register dump controller
interface regfile_dump_ctrl_if #(
   parameter int DATA_SIZE = 32,
   parameter int REG_SIZE  = 5
);
   logic                 i_start;
   logic [DATA_SIZE-1:0] i_rf_data;
   logic                 i_tx_ready;
   logic                 o_rf_read_enable;
   logic [REG_SIZE-1:0]  o_rf_read_addr;
   logic [7:0]           o_tx_data;
   logic                 o_tx_valid;
   logic                 o_busy;
   logic                 o_done;
   modport master (
      input  i_start, i_rf_data, i_tx_ready,
      output o_rf_read_enable, o_rf_read_addr, o_tx_data, o_tx_valid, o_busy, o_done
   );
   modport slave (
      output i_start, i_rf_data, i_tx_ready,
      input  o_rf_read_enable, o_rf_read_addr, o_tx_data, o_tx_valid, o_busy, o_done
   );
endinterface

// File: rtl/regfile_dump_ctrl.sv
// regfile_dump_ctrl: streams every register MSB byte first over a UART byte handshake.
// Define REGDUMP_CHECKSUM_EN to append an XOR checksum byte after the last register.
module regfile_dump_ctrl #(
   parameter int DATA_SIZE = 32,
   parameter int REG_SIZE  = 5,
   parameter int BANK_SIZE = 32
) (
   input  logic               i_clock,
   input  logic               i_reset,
   regfile_dump_ctrl_if.master bus
);
   localparam int NB = DATA_SIZE / 8;
   localparam int CW = NB > 1 ? $clog2(NB) : 1;
   typedef enum logic [2:0] {
      IDLE, REQ, LOAD, SEND,
`ifdef REGDUMP_CHECKSUM_EN
      CKSUM,
`endif
      DONE
   } state_t;
   state_t               state, state_n;
   logic [REG_SIZE-1:0]  index, addr_q;
   logic [CW-1:0]        cnt;
   logic [DATA_SIZE-1:0] shift;
   logic [7:0]           cur_byte;
   logic                 last_byte, last_reg, xfer, tx_valid, rd_en, done;
   assign cur_byte  = shift[DATA_SIZE-1 -: 8];
   assign last_byte = cnt == CW'(NB - 1);
   assign last_reg  = index == REG_SIZE'(BANK_SIZE - 1);
   assign xfer      = tx_valid && bus.i_tx_ready;
`ifdef REGDUMP_CHECKSUM_EN
   localparam state_t FIN = CKSUM;
   logic [7:0] cksum;
   assign bus.o_tx_data = state == CKSUM ? cksum : cur_byte;
   always_ff @(posedge i_clock)
      if (i_reset) cksum <= '0;
      else if (state == IDLE && bus.i_start) cksum <= '0;
      else if (state == SEND && xfer) cksum <= cksum ^ cur_byte;
`else
   localparam state_t FIN = DONE;
   assign bus.o_tx_data = cur_byte;
`endif
   // Address is combinational in REQ so the strobe and address line up in one cycle
   assign bus.o_rf_read_addr   = state == REQ ? index : addr_q;
   assign bus.o_rf_read_enable = rd_en;
   assign bus.o_tx_valid       = tx_valid;
   assign bus.o_busy           = state != IDLE;
   assign bus.o_done           = done;
   always_ff @(posedge i_clock)
      if (i_reset) state <= IDLE;
      else state <= state_n;
   always_comb begin
      state_n  = state;
      rd_en    = 1'b0;
      tx_valid = 1'b0;
      done     = 1'b0;
      case (state)
         IDLE: state_n = bus.i_start ? REQ : IDLE;
         REQ: begin
            rd_en   = 1'b1;
            state_n = LOAD;
         end
         LOAD: state_n = SEND;
         SEND: begin
            tx_valid = 1'b1;
            if (bus.i_tx_ready && last_byte) state_n = last_reg ? FIN : REQ;
         end
`ifdef REGDUMP_CHECKSUM_EN
         CKSUM: begin
            tx_valid = 1'b1;
            if (bus.i_tx_ready) state_n = DONE;
         end
`endif
         DONE: begin
            done    = 1'b1;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge i_clock)
      if (i_reset) begin
         index  <= '0;
         addr_q <= '0;
         cnt    <= '0;
         shift  <= '0;
      end else begin
         if (state == IDLE && bus.i_start) index <= '0;
         if (state == REQ) addr_q <= index;
         if (state == LOAD) begin
            shift <= bus.i_rf_data;
            cnt   <= '0;
         end
         if (state == SEND && xfer) begin
            shift <= shift << 8;
            cnt   <= cnt + 1'b1;
            if (last_byte && !last_reg) index <= index + 1'b1;
         end
      end
endmodule

// File: doc/regfile_dump_ctrl.md
REGFILE_DUMP_CTRL -- requirements
Module: regfile_dump_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
- DATA_SIZE, 32, register width in bits; multiple of 8.
- REG_SIZE, 5, register address width.
- BANK_SIZE, 32, number of registers dumped.

REQ-002 Ports SHALL be, one per line:
- i_clock  in  1  clock; all logic on rising edge.
- i_reset  in  1  reset, synchronous, active-high.
- i_start  in  1  dump request; sampled only in IDLE.
- i_rf_data  in  DATA_SIZE  register bank read-port-A data; registered, valid one cycle after read strobe.
- i_tx_ready  in  1  UART TX can accept a byte this cycle.
- o_rf_read_enable  out  1  register bank debug read strobe.
- o_rf_read_addr  out  REG_SIZE  register bank debug read address.
- o_tx_data  out  8  byte to transmit.
- o_tx_valid  out  1  o_tx_data valid.
- o_busy  out  1  dump in progress; pipeline enable held low by the debug unit while high.
- o_done  out  1  single-cycle pulse, dump complete.

Function
REQ-003 FSM states SHALL be IDLE, REQ, LOAD, SEND, CKSUM (macro only), DONE.
REQ-004 IDLE: on i_start=1, go to REQ with index=0; otherwise stay in IDLE; o_busy=0.
REQ-005 REQ: o_rf_read_enable=1, o_rf_read_addr=index; go to LOAD next cycle.
REQ-006 LOAD: o_rf_read_enable=0; capture i_rf_data into shift register; byte counter=0; go to SEND.
REQ-007 SEND: o_tx_valid=1; o_tx_data = current byte, MSB byte first.
REQ-008 Byte transfer SHALL occur in any cycle with o_tx_valid=1 and i_tx_ready=1; o_tx_data SHALL stay stable until the transfer.
REQ-009 After the (DATA_SIZE/8)th transfer: if index<BANK_SIZE-1, increment index and go to REQ; else go to CKSUM (macro defined) or DONE.
REQ-010 DONE: o_done=1 for exactly one cycle; go to IDLE.
REQ-011 o_busy=1 in every state except IDLE.
REQ-012 i_start while o_busy=1 SHALL be ignored; no queuing.
REQ-013 Index SHALL NOT wrap: the dump stops after address BANK_SIZE-1.
REQ-014 Timing with i_tx_ready held at 1 and i_start sampled in cycle 0: REQ in cycle 1, first byte transferred in cycle 3, o_done in cycle 6*BANK_SIZE+1 (193 for defaults).
REQ-015 i_tx_ready low stalls only SEND/CKSUM; no byte is dropped or duplicated.
REQ-016 o_rf_read_addr SHALL hold its last value outside REQ; o_rf_read_enable=1 only in REQ.

Reset
REQ-017 i_reset=1 at a clock edge SHALL force IDLE and index=0; takes priority over i_start and any in-flight handshake.
REQ-018 While in reset: all outputs 0, shift register 0, checksum 0.
REQ-019 Reset mid-dump SHALL abort the dump without an o_done pulse; the next i_start restarts from address 0.

Configuration
REQ-020 Macro REGDUMP_CHECKSUM_EN defined: checksum clears on leaving IDLE, XOR-accumulates every transferred byte, and is sent as one extra byte in CKSUM under the REQ-008 handshake, then DONE; o_done is one cycle later than REQ-014 (194 for defaults).
REQ-021 Macro REGDUMP_CHECKSUM_EN undefined: CKSUM state and checksum logic absent; byte stream is exactly BANK_SIZE*DATA_SIZE/8 bytes.

Verification
REQ-022 Bank preloaded r[n]=0x11110000+n, i_tx_ready=1, pulse i_start -> 128 bytes 11 11 00 00, 11 11 00 01, ... 11 11 00 1F; o_done in cycle 193.
REQ-023 i_tx_ready toggled 1-cycle high / 3-cycle low -> same 128-byte sequence, no duplicates; o_tx_data stable while o_tx_valid=1 and i_tx_ready=0.
REQ-024 i_start pulsed in cycles 50 and 100 of an active dump -> single dump, exactly one o_done pulse.
REQ-025 i_reset asserted in cycle 40 -> all outputs 0 the next cycle, no o_done; new i_start -> first byte again from r[0].
REQ-026 REGDUMP_CHECKSUM_EN defined, all registers 0 except r[1]=0x000000A5 -> 129th byte 0xA5, o_done in cycle 194.
REQ-027 Check per-register strobe: o_rf_read_enable high exactly 32 cycles; addresses 0..31 in order, each one cycle before its LOAD.
